// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-stage access controller.
package mem_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } mem_state_e;

    localparam logic [3:0] BE_WORD = 4'b1111;
    localparam logic       DT_WORD = 1'b1;
    localparam logic       DT_BYTE = 1'b0;

endpackage

// File: rtl/mem_store_align.sv
// Maps store data and address low bits onto memory byte lanes.
module mem_store_align
    import mem_pkg::*;
(
    input  logic [31:0] wd_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        dt_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o
);

    always_comb begin
        wdata_o = wd_i;
        be_o    = BE_WORD;
        if (dt_i == DT_BYTE) begin
            // Replicate the byte on every lane; the enable picks the live one.
            wdata_o = {4{wd_i[7:0]}};
            be_o    = 4'b0001 << addr_lo_i;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage controller: captures a load/store, runs the req/ack handshake and stalls until done.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] ALU_Result,
    input  logic [31:0] WD,
    input  logic        DT,
    output logic [31:0] D,
    output logic [1:0]  ALU,
    output logic        Stall,
    output logic        Valid,
    output logic        Fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    mem_state_e       state_q;
    logic [31:0]      addr_q;
    logic             we_q;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      d_q;
    logic [1:0]       alu_q;
    logic             valid_q;
    logic             fault_q;

    logic [31:0] align_wdata;
    logic [3:0]  align_be;
    logic        access;
    logic        misaligned;

    mem_store_align u_store_align (
        .wd_i      (WD),
        .addr_lo_i (ALU_Result[1:0]),
        .dt_i      (DT),
        .wdata_o   (align_wdata),
        .be_o      (align_be)
    );

    assign access     = MemRead | MemWrite;
    assign misaligned = (DT == DT_WORD) && (ALU_Result[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            cnt_q   <= '0;
            d_q     <= '0;
            alu_q   <= '0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (access) begin
                        addr_q  <= ALU_Result;
                        we_q    <= MemWrite;
                        wdata_q <= align_wdata;
                        be_q    <= MemWrite ? align_be : BE_WORD;
                        cnt_q   <= '0;
                        if (misaligned) begin
                            state_q <= StDone;
                            valid_q <= 1'b1;
                            fault_q <= 1'b1;
                            alu_q   <= ALU_Result[1:0];
                        end else begin
                            state_q <= StReq;
                        end
                    end
                end
                StReq: begin
                    if (mem_ack) begin
                        if (!we_q) begin
                            d_q <= mem_rdata;
                        end
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        alu_q   <= addr_q[1:0];
                    end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        // Abort: a read returns zero so stale data is never forwarded.
                        if (!we_q) begin
                            d_q <= '0;
                        end
                        state_q <= StDone;
                        valid_q <= 1'b1;
                        fault_q <= 1'b1;
                        alu_q   <= addr_q[1:0];
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall is gated by reset so a flushed pipeline sees zero immediately.
    assign Stall     = !reset && (((state_q == StIdle) && access) || (state_q == StReq));
    assign mem_req   = (state_q == StReq);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q[31:2];
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign D         = d_q;
    assign ALU       = alu_q;
    assign Valid     = valid_q;
    assign Fault     = fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed table, reset corner case and randomized transactions against a transaction-level model.
module tb_mem_access_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite, DT;
    logic [31:0] ALU_Result, WD;
    logic [31:0] D;
    logic [1:0]  ALU;
    logic        Stall, Valid, Fault;
    logic        mem_req, mem_we;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit #(
        .TIMEOUT (TMO),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALU_Result (ALU_Result),
        .WD         (WD),
        .DT         (DT),
        .D          (D),
        .ALU        (ALU),
        .Stall      (Stall),
        .Valid      (Valid),
        .Fault      (Fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        dt;
        int          delay;
        logic [31:0] rdata;
        int          exp_stall;
        int          exp_req;
        logic        exp_fault;
        logic [1:0]  exp_alu;
        logic [31:0] exp_d;
    } txn_t;

    txn_t        vec[8];
    logic [31:0] model_d;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic txn_t mk(input logic rd, input logic wr, input logic [31:0] addr,
                                input logic [31:0] wd, input logic dt, input int delay,
                                input logic [31:0] rdata, input int es, input int er,
                                input logic ef, input logic [1:0] ea, input logic [31:0] ed);
        txn_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.wd = wd; t.dt = dt;
        t.delay = delay; t.rdata = rdata;
        t.exp_stall = es; t.exp_req = er; t.exp_fault = ef; t.exp_alu = ea; t.exp_d = ed;
        return t;
    endfunction

    // Outcome of one access from its inputs alone: counts of stalled and requesting cycles.
    function automatic txn_t predict(input txn_t t, input logic [31:0] dprev);
        bit mis;
        bit tmo;
        mis = t.dt && (t.addr % 4 != 0);
        tmo = t.delay >= TMO;
        t.exp_req   = mis ? 0 : (tmo ? TMO : t.delay + 1);
        t.exp_stall = 1 + t.exp_req;
        t.exp_fault = mis || tmo;
        t.exp_alu   = t.addr[1:0];
        t.exp_d     = (mis || t.wr) ? dprev : (tmo ? 32'h0 : t.rdata);
        return t;
    endfunction

    task automatic run_txn(input txn_t t);
        int          cyc = 0;
        int          stall_n = 0;
        int          req_n = 0;
        bit          done = 0;
        logic [3:0]  ebe;
        logic [31:0] ewd;
        logic [1:0]  lo;
        lo  = t.addr[1:0];
        ebe = (!t.wr || t.dt) ? 4'hF : 4'(1 << lo);
        ewd = t.dt ? t.wd : t.wd[7:0] * 32'h0101_0101;
        MemRead = t.rd; MemWrite = t.wr; ALU_Result = t.addr; WD = t.wd; DT = t.dt;
        #1;
        while (!done && cyc < 30) begin
            if (Valid) begin
                done = 1;
                mem_ack = 1'b0;
                chk("stall_cycles", stall_n, t.exp_stall);
                chk("req_cycles", req_n, t.exp_req);
                chk("fault", {31'b0, Fault}, {31'b0, t.exp_fault});
                chk("alu", {30'b0, ALU}, {30'b0, t.exp_alu});
                chk("d", D, t.exp_d);
                chk("stall_in_done", {31'b0, Stall}, 32'h0);
            end else begin
                if (Stall) stall_n++;
                if (mem_req) begin
                    chk("mem_addr", {2'b0, mem_addr}, {2'b0, t.addr[31:2]});
                    chk("mem_we", {31'b0, mem_we}, {31'b0, t.wr});
                    chk("mem_be", {28'b0, mem_be}, {28'b0, ebe});
                    if (t.wr) chk("mem_wdata", mem_wdata, ewd);
                    mem_ack   = (req_n == t.delay);
                    mem_rdata = mem_ack ? t.rdata : $urandom;
                    req_n++;
                end else begin
                    mem_ack = 1'b0;
                end
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL valid_timeout: got no Valid, expected Valid within 30 cycles");
        end
        // Request still held: the cycle after DONE must be IDLE, not a second request.
        @(negedge clk);
        #1;
        chk("valid_pulse", {31'b0, Valid}, 32'h0);
        chk("idle_no_req", {31'b0, mem_req}, 32'h0);
        MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        chk("idle_stall", {31'b0, Stall}, 32'h0);
        @(negedge clk);
        #1;
    endtask

    initial begin
        txn_t t;
        reset = 1'b1;
        MemRead = 0; MemWrite = 0; DT = 0; ALU_Result = 0; WD = 0;
        mem_ack = 0; mem_rdata = 0;

        vec[0] = mk(1, 0, 32'h100, 32'h0,        1, 0,  32'hDEADBEEF, 2, 1, 0, 2'd0, 32'hDEADBEEF);
        vec[1] = mk(0, 1, 32'h203, 32'h000000A5, 0, 2,  32'h0,        4, 3, 0, 2'd3, 32'hDEADBEEF);
        vec[2] = mk(1, 0, 32'h102, 32'h0,        1, 0,  32'h0,        1, 0, 1, 2'd2, 32'hDEADBEEF);
        vec[3] = mk(1, 0, 32'h7,   32'h0,        0, 99, 32'h55555555, 5, 4, 1, 2'd3, 32'h0);
        vec[4] = mk(1, 1, 32'h10,  32'h12345678, 1, 1,  32'h0,        3, 2, 0, 2'd0, 32'h0);
        vec[5] = mk(1, 0, 32'h1,   32'h0,        0, 3,  32'h11223344, 5, 4, 0, 2'd1, 32'h11223344);
        vec[6] = mk(0, 1, 32'h6,   32'hFFFFFFFF, 1, 0,  32'h0,        1, 0, 1, 2'd2, 32'h11223344);
        vec[7] = mk(0, 1, 32'h8,   32'hCAFEF00D, 1, 0,  32'h0,        2, 1, 0, 2'd0, 32'h11223344);

        #12;
        chk("rst_d", D, 32'h0);
        chk("rst_alu", {30'b0, ALU}, 32'h0);
        chk("rst_stall", {31'b0, Stall}, 32'h0);
        chk("rst_valid", {31'b0, Valid}, 32'h0);
        chk("rst_fault", {31'b0, Fault}, 32'h0);
        chk("rst_req", {31'b0, mem_req}, 32'h0);
        chk("rst_we", {31'b0, mem_we}, 32'h0);
        chk("rst_addr", {2'b0, mem_addr}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_be", {28'b0, mem_be}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;

        foreach (vec[i]) run_txn(vec[i]);

        // Asynchronous reset in the middle of a request.
        MemRead = 1; MemWrite = 0; DT = 1; ALU_Result = 32'h40;
        @(negedge clk);
        #1;
        chk("mid_req_up", {31'b0, mem_req}, 32'h1);
        reset = 1'b1;
        #1;
        chk("async_req_drop", {31'b0, mem_req}, 32'h0);
        chk("async_stall_drop", {31'b0, Stall}, 32'h0);
        chk("async_d_clear", D, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        MemRead = 0;
        #1;
        model_d = 32'h0;
        t = mk(1, 0, 32'h44, 32'h0, 1, 0, 32'h0BADF00D, 0, 0, 0, 2'd0, 32'h0);
        t = predict(t, model_d);
        run_txn(t);
        model_d = t.exp_d;

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind    = $urandom_range(0, 2);
            t.rd    = (kind != 1);
            t.wr    = (kind != 0);
            t.addr  = $urandom;
            if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
            t.wd    = $urandom;
            t.dt    = $urandom_range(0, 1) == 1;
            t.delay = $urandom_range(0, 5);
            t.rdata = $urandom;
            t = predict(t, model_d);
            run_txn(t);
            model_d = t.exp_d;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
